// File: rtl/load_scoreboard.sv
// Decode-side scoreboard for long-latency writes.
// Tracks pending rd bits and stalls decode on hazards.
module load_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regw,
  input  logic             id_long,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             stall,
  output logic             issue,
  output logic [31:0]      pending,
  output logic [2:0]       outstanding,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam logic [2:0] MAX_V = 3'(MAX_OUT);

  logic [31:0]      pending_q, pending_d;
  logic [2:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic [31:0] eff_pend;
  logic        wb_clr;
  logic        raw1, raw2, waw, full;
  logic        set;

  // Hazard detection against pending bits, with writeback clear bypass
  always_comb begin
    wb_clr = wb_valid && (wb_rd != 5'd0) && pending_q[wb_rd];
    eff_pend = pending_q;
    if (wb_clr) eff_pend[wb_rd] = 1'b0;
    raw1 = id_rs1_used && (id_rs1 != 5'd0) && eff_pend[id_rs1];
    raw2 = id_rs2_used && (id_rs2 != 5'd0) && eff_pend[id_rs2];
    waw  = id_regw && (id_rd != 5'd0) && eff_pend[id_rd];
    full = id_long && id_regw && (id_rd != 5'd0)
        && (outstanding_q == MAX_V) && !wb_clr;
    stall = rst_n && id_valid && !flush
         && (raw1 || raw2 || waw || full);
    issue = rst_n && id_valid && !flush && !stall;
    set = issue && id_long && id_regw && (id_rd != 5'd0);
  end

  // Next-state: clear on writeback, then set on issue so set wins
  always_comb begin
    pending_d = pending_q;
    if (wb_clr) pending_d[wb_rd] = 1'b0;
    if (set)    pending_d[id_rd] = 1'b1;
    pending_d[0] = 1'b0;
    outstanding_d = outstanding_q
                  + {2'b00, set}
                  - {2'b00, wb_clr};
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    err_d = err_q || (wb_valid && !wb_clr);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      stall_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
      err_q         <= err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign stall_cnt   = stall_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard.
// Driver queues expectations; monitor checks at negedge.
module tb_load_scoreboard;

  localparam int CW = 4;

  logic          clk, rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used;
  logic [4:0]    id_rs1, id_rs2, id_rd, wb_rd;
  logic          id_regw, id_long, flush, wb_valid;
  logic          stall, issue, err;
  logic [31:0]   pending;
  logic [2:0]    outstanding;
  logic [CW-1:0] stall_cnt;

  load_scoreboard #(.MAX_OUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regw(id_regw),
    .id_long(id_long), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .issue(issue),
    .pending(pending),
    .outstanding(outstanding),
    .stall_cnt(stall_cnt), .err(err)
  );

  typedef struct {
    bit            kind;
    logic          stall;
    logic          issue;
    logic [31:0]   pend;
    logic [2:0]    outs;
    logic [CW-1:0] sc;
    logic          err;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    done    = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic exp_comb(string nm, logic s, logic i);
    exp_t e;
    e = '{kind: 1'b0, stall: s, issue: i,
          pend: '0, outs: '0, sc: '0, err: 1'b0};
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic exp_state(string nm, logic [31:0] p,
                           logic [2:0] o, logic [CW-1:0] c,
                           logic er);
    exp_t e;
    e = '{kind: 1'b1, stall: 1'b0, issue: 1'b0,
          pend: p, outs: o, sc: c, err: er};
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic chk(string nm, string f, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h",
               nm, f, act, req);
    end
  endtask

  // monitor: drain all queued expectations at each negedge
  initial begin
    exp_t e;
    string nm;
    while (!done) begin
      @(negedge clk);
      while (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.kind == 1'b0) begin
          chk(nm, "stall", int'(stall), int'(e.stall));
          chk(nm, "issue", int'(issue), int'(e.issue));
        end else begin
          chk(nm, "pending", int'(pending), int'(e.pend));
          chk(nm, "outstanding", int'(outstanding),
              int'(e.outs));
          chk(nm, "stall_cnt", int'(stall_cnt), int'(e.sc));
          chk(nm, "err", int'(err), int'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0;
    id_rs2 = 0; id_rs2_used = 0; id_rd = 0;
    id_regw = 0; id_long = 0; flush = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic op(logic [4:0] rd, logic regw, logic lng,
                    logic [4:0] rs1, logic u1,
                    logic [4:0] rs2, logic u2);
    id_valid = 1; id_rd = rd; id_regw = regw;
    id_long = lng; id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2;
  endtask

  task automatic wb(logic v, logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  initial begin
    rst_n = 0;
    idle();
    step();
    op(5'd5, 1, 1, 0, 0, 0, 0);
    exp_comb("reset_comb", 0, 0);
    exp_state("reset", 32'h0, 3'd0, 4'd0, 0);
    step();
    idle();
    rst_n = 1;

    // load-use
    op(5'd5, 1, 1, 0, 0, 0, 0);
    exp_comb("lu_issue", 0, 1);
    step();
    op(5'd6, 1, 0, 5'd5, 1, 0, 0);
    exp_comb("lu_stall", 1, 0);
    exp_state("lu_pend", 32'h20, 3'd1, 4'd0, 0);
    step();
    wb(1, 5'd5);
    exp_comb("lu_bypass", 0, 1);
    exp_state("lu_cnt", 32'h20, 3'd1, 4'd1, 0);
    step();
    idle();
    exp_state("lu_done", 32'h0, 3'd0, 4'd1, 0);

    // WAW
    op(5'd7, 1, 1, 0, 0, 0, 0);
    step();
    op(5'd7, 1, 0, 0, 0, 0, 0);
    exp_comb("waw_stall", 1, 0);
    step();
    wb(1, 5'd7);
    exp_comb("waw_bypass", 0, 1);
    step();
    idle();
    exp_state("waw_done", 32'h0, 3'd0, 4'd2, 0);

    // full
    for (int r = 1; r <= 4; r++) begin
      op(5'(r), 1, 1, 0, 0, 0, 0);
      exp_comb("full_fill", 0, 1);
      step();
    end
    op(5'd6, 1, 1, 0, 0, 0, 0);
    exp_comb("full_stall", 1, 0);
    exp_state("full_pend", 32'h1E, 3'd4, 4'd2, 0);
    step();
    wb(1, 5'd1);
    exp_comb("full_bypass", 0, 1);
    step();
    idle();
    exp_state("full_swap", 32'h5C, 3'd4, 4'd3, 0);
    wb(1, 5'd2); step();
    wb(1, 5'd3); step();
    wb(1, 5'd4); step();
    wb(1, 5'd6); step();
    idle();
    exp_state("full_drain", 32'h0, 3'd0, 4'd3, 0);

    // same-reg set/clear
    op(5'd9, 1, 1, 0, 0, 0, 0);
    step();
    wb(1, 5'd9);
    exp_comb("same_issue", 0, 1);
    step();
    idle();
    exp_state("same_keep", 32'h200, 3'd1, 4'd3, 0);
    wb(1, 5'd9);
    step();
    idle();
    exp_state("same_clr", 32'h0, 3'd0, 4'd3, 0);

    // x0 and err
    op(5'd0, 1, 1, 0, 0, 0, 0);
    exp_comb("x0_issue", 0, 1);
    step();
    idle();
    exp_state("x0_untracked", 32'h0, 3'd0, 4'd3, 0);
    wb(1, 5'd12);
    step();
    idle();
    exp_state("err_set", 32'h0, 3'd0, 4'd3, 1);
    step();
    exp_state("err_sticky", 32'h0, 3'd0, 4'd3, 1);

    // flush, then async reset mid-stall
    op(5'd5, 1, 1, 0, 0, 0, 0);
    step();
    op(5'd8, 1, 0, 5'd5, 1, 0, 0);
    flush = 1;
    exp_comb("flush_mask", 0, 0);
    step();
    exp_state("flush_cnt", 32'h20, 3'd1, 4'd3, 1);
    flush = 0;
    exp_comb("unflush_stall", 1, 0);
    step();
    #1;
    rst_n = 0;
    exp_comb("rst_comb", 0, 0);
    exp_state("rst_async", 32'h0, 3'd0, 4'd0, 0);
    @(negedge clk);
    #1;
    rst_n = 1;
    idle();
    step();
    wb(1, 5'd5);
    step();
    idle();
    exp_state("rst_discard_err", 32'h0, 3'd0, 4'd0, 1);

    // rs2 stall and counter saturation
    op(5'd10, 1, 1, 0, 0, 0, 0);
    step();
    op(5'd11, 1, 0, 0, 0, 5'd10, 1);
    exp_comb("rs2_stall", 1, 0);
    repeat (20) step();
    exp_state("sat", 32'h400, 3'd1, 4'd15, 1);
    step();
    idle();

    @(negedge clk);
    #1;
    done = 1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
